// File: rtl/dcache_refill_ctrl.sv
// Dcache miss handler: optional victim write-back, then a line read from ram,
// returning the refilled line (or a timeout error) as a one-cycle pulse.
module dcache_refill_ctrl #(
  parameter int unsigned LINE_BYTES     = 16,
  parameter int unsigned WB_CYCLES      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_req_i,
  input  logic [31:0]  miss_addr_i,
  input  logic         victim_dirty_i,
  input  logic [31:0]  victim_addr_i,
  input  logic [127:0] victim_data_i,
  output logic         miss_busy_o,
  output logic         refill_valid_o,
  output logic [127:0] refill_data_o,
  output logic [31:0]  refill_addr_o,
  output logic         refill_err_o,
  output logic         Dcache_rd_req_o,
  output logic [31:0]  Dcache_rd_addr_o,
  output logic         Dcache_wb_req_o,
  output logic [31:0]  Dcache_wb_addr_o,
  output logic [127:0] Dcache_data_ram_o,
  input  logic [127:0] ram_data_i,
  input  logic         ram_ready_i
);

  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WB_W       = (WB_CYCLES < 1) ? 1 : $clog2(WB_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [WB_W-1:0] WB_INIT  = WB_W'(WB_CYCLES);
  localparam logic            HAS_WB   = (WB_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e         state_q;
  logic [31:0]    miss_addr_q;
  logic [31:0]    victim_addr_q;
  logic [127:0]   victim_data_q;
  logic [WB_W-1:0] wb_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic           timeout_q;

  logic           busy_q;
  logic           refill_valid_q;
  logic [127:0]   refill_data_q;
  logic [31:0]    refill_addr_q;
  logic           refill_err_q;
  logic           rd_req_q;
  logic [31:0]    rd_addr_q;
  logic           wb_req_q;
  logic [31:0]    wb_addr_q;
  logic [127:0]   wb_data_q;

  // Ram handshake: both requests are plain levels with no ack. wb_req is held
  // for exactly WB_CYCLES cycles (each sampled cycle is an idempotent commit).
  // rd_req is held until ram_ready_i is seen while rd_req is already on the
  // bus; ready seen before that is stale and ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      miss_addr_q    <= '0;
      victim_addr_q  <= '0;
      victim_data_q  <= '0;
      wb_cnt_q       <= '0;
      to_cnt_q       <= '0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      refill_valid_q <= 1'b0;
      refill_data_q  <= '0;
      refill_addr_q  <= '0;
      refill_err_q   <= 1'b0;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= '0;
      wb_req_q       <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
    end else begin
      refill_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q       <= 1'b0;
          refill_err_q <= 1'b0;
          to_cnt_q     <= '0;
          timeout_q    <= 1'b0;
          if (miss_req_i) begin
            miss_addr_q   <= miss_addr_i & ALIGN_MASK;
            victim_addr_q <= victim_addr_i & ALIGN_MASK;
            victim_data_q <= victim_data_i;
            wb_cnt_q      <= WB_INIT;
            busy_q        <= 1'b1;
            state_q       <= (victim_dirty_i && HAS_WB) ? S_WB : S_RD;
          end
        end

        S_WB: begin
          wb_req_q  <= 1'b1;
          wb_addr_q <= victim_addr_q;
          wb_data_q <= victim_data_q;
          wb_cnt_q  <= wb_cnt_q - WB_W'(1);
          if (wb_cnt_q == WB_W'(1)) begin
            state_q <= S_RD;
          end
        end

        S_RD: begin
          wb_req_q <= 1'b0;
          // Ready beats the timeout when both land on the same cycle.
          if (rd_req_q && ram_ready_i) begin
            rd_req_q      <= 1'b0;
            refill_data_q <= ram_data_i;
            timeout_q     <= 1'b0;
            state_q       <= S_DONE;
          end else if (to_cnt_q == TO_LIMIT) begin
            rd_req_q      <= 1'b0;
            refill_data_q <= '0;
            timeout_q     <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= miss_addr_q;
            to_cnt_q  <= to_cnt_q + TO_W'(1);
          end
        end

        S_DONE: begin
          refill_valid_q <= 1'b1;
          refill_addr_q  <= miss_addr_q;
          refill_err_q   <= timeout_q;
          busy_q         <= 1'b0;
          to_cnt_q       <= '0;
          state_q        <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign miss_busy_o       = busy_q;
  assign refill_valid_o    = refill_valid_q;
  assign refill_data_o     = refill_data_q;
  assign refill_addr_o     = refill_addr_q;
  assign refill_err_o      = refill_err_q;
  assign Dcache_rd_req_o   = rd_req_q;
  assign Dcache_rd_addr_o  = rd_addr_q;
  assign Dcache_wb_req_o   = wb_req_q;
  assign Dcache_wb_addr_o  = wb_addr_q;
  assign Dcache_data_ram_o = wb_data_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(Dcache_rd_req_o && Dcache_wb_req_o));

  a_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    refill_valid_o |=> !refill_valid_o);

  a_rd_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    Dcache_rd_req_o |-> ((Dcache_rd_addr_o & ~ALIGN_MASK) == 32'd0));

  a_wb_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    Dcache_wb_req_o |-> ((Dcache_wb_addr_o & ~ALIGN_MASK) == 32'd0));

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Bench for dcache_refill_ctrl: behavioural ram, cycle-count latency model and
// a line-memory reference for write-back/readback.
module tb_dcache_refill_ctrl;

  localparam int LB  = 16;
  localparam int WBC = 1;
  localparam int TO  = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_req_i;
  logic [31:0]  miss_addr_i;
  logic         victim_dirty_i;
  logic [31:0]  victim_addr_i;
  logic [127:0] victim_data_i;
  logic         miss_busy_o;
  logic         refill_valid_o;
  logic [127:0] refill_data_o;
  logic [31:0]  refill_addr_o;
  logic         refill_err_o;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         wb_req;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic [127:0] ram_data_i;
  logic         ram_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_refill_ctrl #(
    .LINE_BYTES(LB), .WB_CYCLES(WBC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i),
    .victim_dirty_i(victim_dirty_i), .victim_addr_i(victim_addr_i),
    .victim_data_i(victim_data_i),
    .miss_busy_o(miss_busy_o), .refill_valid_o(refill_valid_o),
    .refill_data_o(refill_data_o), .refill_addr_o(refill_addr_o),
    .refill_err_o(refill_err_o),
    .Dcache_rd_req_o(rd_req), .Dcache_rd_addr_o(rd_addr),
    .Dcache_wb_req_o(wb_req), .Dcache_wb_addr_o(wb_addr),
    .Dcache_data_ram_o(wb_data),
    .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i)
  );

  logic [356:0] all_o;
  assign all_o = {miss_busy_o, refill_valid_o, refill_data_o, refill_addr_o, refill_err_o,
                  rd_req, rd_addr, wb_req, wb_addr, wb_data};

  // ---------------- behavioural ram ----------------
  logic [127:0] ram_mem [logic [31:0]];
  int           ram_lat = 1;
  bit           ram_never = 0;
  bit           stale_ready = 0;
  int           ram_cnt;
  logic         ram_rdy_q;
  logic [127:0] ram_rdata_q;

  function automatic logic [127:0] pattern(input logic [31:0] a);
    return {a ^ 32'h5A5A_0001, a ^ 32'h1234_0000, ~a, a};
  endfunction

  function automatic logic [127:0] ram_lookup(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return pattern(a);
  endfunction

  assign ram_ready_i = ram_rdy_q | stale_ready;
  assign ram_data_i  = ram_rdy_q ? ram_rdata_q : {4{32'hDEAD_BEEF}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cnt     <= 0;
      ram_rdy_q   <= 1'b0;
      ram_rdata_q <= '0;
    end else begin
      if (wb_req) ram_mem[wb_addr] = wb_data;
      if (rd_req && !ram_rdy_q) begin
        if (!ram_never && (ram_cnt + 1 == ram_lat)) begin
          ram_rdy_q   <= 1'b1;
          ram_rdata_q <= ram_lookup(rd_addr);
          ram_cnt     <= 0;
        end else begin
          ram_cnt <= ram_cnt + 1;
        end
      end else begin
        ram_rdy_q <= 1'b0;
        if (!rd_req) ram_cnt <= 0;
      end
    end
  end

  // ---------------- monitor (cumulative counts) ----------------
  int           mon_wb_cyc = 0, mon_rd_cyc = 0, mon_vld = 0, mon_overlap = 0, mon_misalign = 0;
  logic [31:0]  mon_wb_addr = '0, mon_rd_addr = '0;
  logic [127:0] mon_wb_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_req) begin
        mon_wb_cyc++;
        mon_wb_addr = wb_addr;
        mon_wb_data = wb_data;
        if (wb_addr[3:0] != 4'h0) mon_misalign++;
      end
      if (rd_req) begin
        mon_rd_cyc++;
        mon_rd_addr = rd_addr;
        if (rd_addr[3:0] != 4'h0) mon_misalign++;
      end
      if (wb_req && rd_req) mon_overlap++;
      if (refill_valid_o) mon_vld++;
    end
  end

  // ---------------- reference model ----------------
  logic [127:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~(32'(LB) - 32'd1);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  // Cycles from the accepting edge to refill_valid, plus rd_req high cycles.
  function automatic void model(input bit dirty, input int lat, input bit never,
                                output int n, output bit err, output int rdc);
    int wb;
    wb = dirty ? WBC : 0;
    if (!never && (lat + 1 <= TO)) begin
      n = wb + lat + 3; err = 1'b0; rdc = lat + 1;
    end else begin
      n = wb + TO + 2;  err = 1'b1; rdc = TO;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] ma, input bit dirty, input logic [31:0] va,
                         input logic [127:0] vd, input bit stale, input int poke_at,
                         output int n, output logic [31:0] ra, output logic [127:0] rdat,
                         output logic re, output bit seen,
                         output logic busy_acc, output logic vld_acc);
    miss_addr_i = ma; victim_dirty_i = dirty; victim_addr_i = va; victim_data_i = vd;
    stale_ready = stale;
    miss_req_i = 1'b1;
    @(posedge clk); #1;
    miss_req_i = 1'b0;
    miss_addr_i = $urandom; victim_addr_i = $urandom;
    victim_data_i = ~vd; victim_dirty_i = ~dirty;
    busy_acc = miss_busy_o; vld_acc = refill_valid_o;
    seen = 0; n = 0; ra = '0; rdat = '0; re = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      stale_ready = 1'b0;
      if (i == poke_at) begin
        miss_req_i = 1'b1; miss_addr_i = 32'h0000_0F00; victim_dirty_i = 1'b0;
      end else begin
        miss_req_i = 1'b0;
      end
      if (refill_valid_o) begin
        seen = 1; n = i; ra = refill_addr_o; rdat = refill_data_o; re = refill_err_o;
        break;
      end
    end
    miss_req_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    miss_req_i = 0; miss_addr_i = '0; victim_dirty_i = 0; victim_addr_i = '0; victim_data_i = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (all_o !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", all_o); end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    n_cmp++; if (all_o !== '0) begin n_err++; $display("FAIL reset_idle_outputs: got %h expected 0", all_o); end
  endtask

  task automatic test_clean_miss;
    logic [127:0] line; int n, en, erdc, rd0; bit ee, seen; logic [31:0] ra; logic [127:0] rdat;
    logic re, ba, va;
    for (int i = 0; i < 16; i++) line[8*i +: 8] = 8'(i);
    ram_mem[32'h120] = line; ref_mem[32'h120] = line;
    ram_lat = 1; ram_never = 0;
    rd0 = mon_rd_cyc;
    do_miss(32'h0000_0123, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    model(0, 1, 0, en, ee, erdc);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL clean_seen: no refill_valid within bound"); end
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL clean_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (ra !== 32'h120) begin n_err++; $display("FAIL clean_addr: got %h expected 120", ra); end
    n_cmp++; if (rdat !== ref_line(32'h120)) begin n_err++; $display("FAIL clean_data: got %h expected %h", rdat, ref_line(32'h120)); end
    n_cmp++; if (re !== 1'b0) begin n_err++; $display("FAIL clean_err: got %b expected 0", re); end
    n_cmp++; if (ba !== 1'b1) begin n_err++; $display("FAIL clean_busy: got %b expected 1", ba); end
    n_cmp++; if (miss_busy_o !== 1'b0) begin n_err++; $display("FAIL clean_busy_at_valid: got %b expected 0", miss_busy_o); end
    n_cmp++; if (mon_rd_addr !== 32'h120) begin n_err++; $display("FAIL clean_rd_addr: got %h expected 120", mon_rd_addr); end
    n_cmp++; if (mon_rd_cyc - rd0 !== erdc) begin n_err++; $display("FAIL clean_rd_cycles: got %0d expected %0d", mon_rd_cyc - rd0, erdc); end
    idle(2);
  endtask

  task automatic test_dirty_miss;
    int n, en, erdc, wb0, ov0; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    logic [127:0] aa;
    aa = {16{8'hAA}};
    wb0 = mon_wb_cyc; ov0 = mon_overlap;
    ram_lat = 1; ram_never = 0;
    do_miss(32'h80, 1, 32'h40, aa, 0, 0, n, ra, rdat, re, seen, ba, va);
    ref_mem[32'h40] = aa;
    model(1, 1, 0, en, ee, erdc);
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL dirty_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (mon_wb_cyc - wb0 !== WBC) begin n_err++; $display("FAIL dirty_wb_cycles: got %0d expected %0d", mon_wb_cyc - wb0, WBC); end
    n_cmp++; if (mon_wb_addr !== 32'h40) begin n_err++; $display("FAIL dirty_wb_addr: got %h expected 40", mon_wb_addr); end
    n_cmp++; if (mon_wb_data !== aa) begin n_err++; $display("FAIL dirty_wb_data: got %h expected %h", mon_wb_data, aa); end
    n_cmp++; if (mon_overlap !== ov0) begin n_err++; $display("FAIL dirty_overlap: got %0d expected %0d", mon_overlap, ov0); end
    n_cmp++; if (ra !== 32'h80) begin n_err++; $display("FAIL dirty_refill_addr: got %h expected 80", ra); end
    idle(2);
    do_miss(32'h44, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    n_cmp++; if (rdat !== ref_line(32'h40)) begin n_err++; $display("FAIL dirty_readback: got %h expected %h", rdat, ref_line(32'h40)); end
    idle(2);
  endtask

  task automatic test_slow_ram;
    int n, en, erdc, rd0, v0; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    ram_lat = 10; ram_never = 0;
    rd0 = mon_rd_cyc; v0 = mon_vld;
    do_miss(32'h0000_0230, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    model(0, 10, 0, en, ee, erdc);
    idle(4);
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL slow_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (mon_rd_cyc - rd0 !== erdc) begin n_err++; $display("FAIL slow_rd_cycles: got %0d expected %0d", mon_rd_cyc - rd0, erdc); end
    n_cmp++; if (mon_vld - v0 !== 1) begin n_err++; $display("FAIL slow_pulses: got %0d expected 1", mon_vld - v0); end
    n_cmp++; if (rdat !== ref_line(32'h230)) begin n_err++; $display("FAIL slow_data: got %h expected %h", rdat, ref_line(32'h230)); end
  endtask

  task automatic test_timeout;
    int n, en, erdc, rd0; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    ram_never = 1; ram_lat = 1;
    rd0 = mon_rd_cyc;
    do_miss(32'h0000_0350, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    model(0, 1, 1, en, ee, erdc);
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (re !== ee) begin n_err++; $display("FAIL timeout_err: got %b expected %b", re, ee); end
    n_cmp++; if (rdat !== '0) begin n_err++; $display("FAIL timeout_data: got %h expected 0", rdat); end
    n_cmp++; if (mon_rd_cyc - rd0 !== erdc) begin n_err++; $display("FAIL timeout_rd_cycles: got %0d expected %0d", mon_rd_cyc - rd0, erdc); end
    idle(2);
    n_cmp++; if (refill_err_o !== 1'b0) begin n_err++; $display("FAIL timeout_err_clear: got %b expected 0", refill_err_o); end
    // Boundary: ready on the exact timeout cycle (data wins), then one cycle too late.
    for (int k = 0; k < 2; k++) begin
      ram_never = 0; ram_lat = TO - 1 + k;
      do_miss(32'h0000_0360, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
      model(0, ram_lat, 0, en, ee, erdc);
      n_cmp++; if (n !== en) begin n_err++; $display("FAIL edge%0d_latency: got %0d expected %0d", k, n, en); end
      n_cmp++; if (re !== ee) begin n_err++; $display("FAIL edge%0d_err: got %b expected %b", k, re, ee); end
      n_cmp++; if (rdat !== (ee ? 128'd0 : ref_line(32'h360))) begin n_err++; $display("FAIL edge%0d_data: got %h", k, rdat); end
      idle(3);
    end
    ram_lat = 1;
  endtask

  task automatic test_stale_ready;
    int n, en, erdc; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    ram_lat = 1; ram_never = 0;
    do_miss(32'h0000_0470, 0, 32'h0, '0, 1, 0, n, ra, rdat, re, seen, ba, va);
    model(0, 1, 0, en, ee, erdc);
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL stale_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (rdat !== ref_line(32'h470)) begin n_err++; $display("FAIL stale_data: got %h expected %h", rdat, ref_line(32'h470)); end
    idle(2);
  endtask

  task automatic test_busy_ignore;
    int n, en, erdc, v0; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    ram_lat = 3; ram_never = 0;
    v0 = mon_vld;
    do_miss(32'h0000_0588, 0, 32'h0, '0, 0, 2, n, ra, rdat, re, seen, ba, va);
    model(0, 3, 0, en, ee, erdc);
    idle(10);
    n_cmp++; if (ra !== 32'h580) begin n_err++; $display("FAIL busy_addr: got %h expected 580", ra); end
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL busy_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (mon_vld - v0 !== 1) begin n_err++; $display("FAIL busy_pulses: got %0d expected 1", mon_vld - v0); end
    ram_lat = 1;
  endtask

  task automatic test_back_to_back;
    int n, en, erdc; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    ram_lat = 1; ram_never = 0;
    do_miss(32'h0000_0610, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    do_miss(32'h0000_0620, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    model(0, 1, 0, en, ee, erdc);
    n_cmp++; if (ba !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy: got %b expected 1", ba); end
    n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_width: got %b expected 0", va); end
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (ra !== 32'h620) begin n_err++; $display("FAIL b2b_addr: got %h expected 620", ra); end
    idle(2);
  endtask

  task automatic test_reset_mid_wb;
    int n, en, erdc; bit ee, seen; logic [31:0] ra; logic [127:0] rdat; logic re, ba, va;
    miss_addr_i = 32'h500; victim_dirty_i = 1; victim_addr_i = 32'h300;
    victim_data_i = {4{32'hC0FF_EE00}}; miss_req_i = 1;
    @(posedge clk); #1; miss_req_i = 0;
    @(posedge clk); #1;
    n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL rstwb_in_wb: got %b expected 1", wb_req); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_cmp++; if (all_o !== '0) begin n_err++; $display("FAIL rstwb_outputs: got %h expected 0", all_o); end
    idle(3);
    n_cmp++; if ({refill_valid_o, miss_busy_o} !== 2'b00) begin n_err++; $display("FAIL rstwb_held: got %b expected 00", {refill_valid_o, miss_busy_o}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ram_lat = 1; ram_never = 0;
    do_miss(32'h300, 0, 32'h0, '0, 0, 0, n, ra, rdat, re, seen, ba, va);
    model(0, 1, 0, en, ee, erdc);
    n_cmp++; if (n !== en) begin n_err++; $display("FAIL rstwb_after_latency: got %0d expected %0d", n, en); end
    n_cmp++; if (rdat !== ref_line(32'h300)) begin n_err++; $display("FAIL rstwb_no_commit: got %h expected %h", rdat, ref_line(32'h300)); end
    idle(2);
  endtask

  task automatic test_random;
    int n, en, erdc, rd0, wb0, lat; bit ee, seen, dirty, never; logic [31:0] ma, vad, ra;
    logic [127:0] vd, rdat, exp_d; logic re, ba, va;
    for (int it = 0; it < 24; it++) begin
      ma    = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd16 + 32'($urandom_range(0, 15));
      vad   = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd16 + 32'($urandom_range(0, 15));
      vd    = {$urandom, $urandom, $urandom, $urandom};
      dirty = ($urandom_range(0, 1) == 1);
      lat   = $urandom_range(1, TO + 1);
      never = ($urandom_range(0, 7) == 0);
      ram_lat = lat; ram_never = never;
      rd0 = mon_rd_cyc; wb0 = mon_wb_cyc;
      do_miss(ma, dirty, vad, vd, 0, 0, n, ra, rdat, re, seen, ba, va);
      if (dirty) ref_mem[align(vad)] = vd;
      model(dirty, lat, never, en, ee, erdc);
      exp_d = ee ? 128'd0 : ref_line(align(ma));
      n_cmp++; if (n !== en) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, n, en); end
      n_cmp++; if (ra !== align(ma)) begin n_err++; $display("FAIL rand%0d_addr: got %h expected %h", it, ra, align(ma)); end
      n_cmp++; if (rdat !== exp_d) begin n_err++; $display("FAIL rand%0d_data: got %h expected %h", it, rdat, exp_d); end
      n_cmp++; if (re !== ee) begin n_err++; $display("FAIL rand%0d_err: got %b expected %b", it, re, ee); end
      n_cmp++; if (mon_wb_cyc - wb0 !== (dirty ? WBC : 0)) begin n_err++; $display("FAIL rand%0d_wb_cycles: got %0d", it, mon_wb_cyc - wb0); end
      n_cmp++; if (mon_rd_cyc - rd0 !== erdc) begin n_err++; $display("FAIL rand%0d_rd_cycles: got %0d expected %0d", it, mon_rd_cyc - rd0, erdc); end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    n_cmp++; if (mon_overlap !== 0) begin n_err++; $display("FAIL rand_overlap: got %0d expected 0", mon_overlap); end
    n_cmp++; if (mon_misalign !== 0) begin n_err++; $display("FAIL rand_misalign: got %0d expected 0", mon_misalign); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_clean_miss;
    test_dirty_miss;
    test_slow_ram;
    test_timeout;
    test_stale_ready;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_wb;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
